// File: rtl/tick_timer.sv
// ============================================================================
// Module   : tick_timer
// Brief    : Bus-mapped tick counter with period compare, auto-reload and IRQ.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tick_timer #(
    parameter logic [7:0] BASE_ADDR   = 8'hF0,
    parameter int         Timer_Width = 8
) (
    input  logic       CLK,
    input  logic       Reset,
    input  logic       TICK_IN,
    input  logic [7:0] BUS_ADDR,
    input  logic [7:0] BUS_DATA_IN,
    input  logic       BUS_WE,
    output logic [7:0] BUS_DATA_OUT,
    output logic       BUS_DATA_OE,
    output logic       IRQ_RAISE,
    input  logic       IRQ_ACK
);

    localparam logic [1:0] c_OFF_CTRL   = 2'd0;
    localparam logic [1:0] c_OFF_PERIOD = 2'd1;
    localparam logic [1:0] c_OFF_COUNT  = 2'd2;
    localparam logic [1:0] c_OFF_STATUS = 2'd3;
    localparam logic [Timer_Width-1:0] c_ONE = Timer_Width'(1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_RUNNING = 2'd1,
        S_DONE    = 2'd2
    } state_t;

    state_t                 r_state;
    state_t                 w_state_next;
    logic [2:0]             r_ctrl;
    logic [Timer_Width-1:0] r_period;
    logic [Timer_Width-1:0] r_count;
    logic [Timer_Width-1:0] w_count_next;
    logic                   r_pending;
    logic                   r_done;
    logic                   w_expire;

    logic [8:0]             w_addr_diff;
    logic                   w_in_range;
    logic [1:0]             w_offset;
    logic                   w_wr_ctrl;
    logic                   w_wr_period;
    logic                   w_wr_status;
    logic                   w_rd_en;
    logic [7:0]             w_rd_data;
    logic [7:0]             w_period_ext;
    logic [7:0]             w_count_ext;

    // 9-bit subtraction: addresses below the base wrap to >= 256 and fall out of range
    assign w_addr_diff = {1'b0, BUS_ADDR} - {1'b0, BASE_ADDR};
    assign w_in_range  = (w_addr_diff < 9'd4);
    assign w_offset    = w_addr_diff[1:0];

    assign w_wr_ctrl   = BUS_WE && w_in_range && (w_offset == c_OFF_CTRL);
    assign w_wr_period = BUS_WE && w_in_range && (w_offset == c_OFF_PERIOD);
    assign w_wr_status = BUS_WE && w_in_range && (w_offset == c_OFF_STATUS);
    assign w_rd_en     = !BUS_WE && w_in_range;

    always_ff @(posedge CLK) begin
        if (Reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // A CTRL write overrides any same-cycle tick
    always_comb begin
        w_state_next = r_state;
        w_count_next = r_count;
        w_expire     = 1'b0;
        if (w_wr_ctrl) begin
            w_count_next = '0;
            w_state_next = BUS_DATA_IN[0] ? S_RUNNING : S_IDLE;
        end else if ((r_state == S_RUNNING) && TICK_IN) begin
            if (r_count >= r_period) begin
                w_expire     = 1'b1;
                w_count_next = '0;
                w_state_next = r_ctrl[2] ? S_RUNNING : S_DONE;
            end else begin
                w_count_next = r_count + c_ONE;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            r_ctrl    <= '0;
            r_period  <= '0;
            r_count   <= '0;
            r_pending <= 1'b0;
            r_done    <= 1'b0;
            IRQ_RAISE <= 1'b0;
        end else begin
            r_count <= w_count_next;
            if (w_wr_ctrl) begin
                r_ctrl <= BUS_DATA_IN[2:0];
            end
            if (w_wr_period) begin
                r_period <= BUS_DATA_IN[Timer_Width-1:0];
            end
            // Expiry wins over a same-cycle clear
            if (w_expire) begin
                r_pending <= 1'b1;
            end else if (IRQ_ACK || (w_wr_status && BUS_DATA_IN[0])) begin
                r_pending <= 1'b0;
            end
            if (w_expire && !r_ctrl[2]) begin
                r_done <= 1'b1;
            end else if (w_wr_status && BUS_DATA_IN[1]) begin
                r_done <= 1'b0;
            end
            IRQ_RAISE <= r_pending && r_ctrl[1];
        end
    end

    always_comb begin
        w_period_ext = '0;
        w_count_ext  = '0;
        w_period_ext[Timer_Width-1:0] = r_period;
        w_count_ext[Timer_Width-1:0]  = r_count;
    end

    always_comb begin
        w_rd_data = '0;
        case (w_offset)
            c_OFF_CTRL:   w_rd_data = {5'b0, r_ctrl};
            c_OFF_PERIOD: w_rd_data = w_period_ext;
            c_OFF_COUNT:  w_rd_data = w_count_ext;
            c_OFF_STATUS: w_rd_data = {6'b0, r_done, r_pending};
            default:      w_rd_data = '0;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            BUS_DATA_OUT <= '0;
            BUS_DATA_OE  <= 1'b0;
        end else begin
            BUS_DATA_OUT <= w_rd_en ? w_rd_data : 8'h00;
            BUS_DATA_OE  <= w_rd_en;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_tick_timer.sv
// ============================================================================
// Module   : tb_tick_timer
// Brief    : Directed self-checking bench for tick_timer.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_tick_timer;

    logic       CLK = 1'b0;
    logic       Reset;
    logic       TICK_IN;
    logic [7:0] BUS_ADDR;
    logic [7:0] BUS_DATA_IN;
    logic       BUS_WE;
    logic [7:0] BUS_DATA_OUT;
    logic       BUS_DATA_OE;
    logic       IRQ_RAISE;
    logic       IRQ_ACK;

    int total = 0;
    int bad   = 0;

    tick_timer #(.BASE_ADDR(8'hF0), .Timer_Width(8)) dut (
        .CLK          (CLK),
        .Reset        (Reset),
        .TICK_IN      (TICK_IN),
        .BUS_ADDR     (BUS_ADDR),
        .BUS_DATA_IN  (BUS_DATA_IN),
        .BUS_WE       (BUS_WE),
        .BUS_DATA_OUT (BUS_DATA_OUT),
        .BUS_DATA_OE  (BUS_DATA_OE),
        .IRQ_RAISE    (IRQ_RAISE),
        .IRQ_ACK      (IRQ_ACK)
    );

    always #5 CLK = ~CLK;

    task automatic bus_wr(input logic [7:0] a, input logic [7:0] d);
        @(negedge CLK);
        BUS_ADDR = a; BUS_DATA_IN = d; BUS_WE = 1'b1;
        @(negedge CLK);
        BUS_WE = 1'b0; BUS_ADDR = 8'h00; BUS_DATA_IN = 8'h00;
    endtask

    task automatic bus_rd(input logic [7:0] a, output logic [7:0] d, output logic oe);
        @(negedge CLK);
        BUS_ADDR = a; BUS_WE = 1'b0;
        @(negedge CLK);
        d = BUS_DATA_OUT; oe = BUS_DATA_OE;
        BUS_ADDR = 8'h00;
    endtask

    task automatic tick();
        @(negedge CLK);
        TICK_IN = 1'b1;
        @(negedge CLK);
        TICK_IN = 1'b0;
    endtask

    task automatic test_reset();
        logic [7:0] d; logic oe;
        Reset = 1'b1;
        repeat (2) @(negedge CLK);
        total++;
        if (BUS_DATA_OE !== 1'b0 || BUS_DATA_OUT !== 8'h00 || IRQ_RAISE !== 1'b0) begin
            bad++; $display("FAIL reset_outputs oe=%b out=%h irq=%b want 0/00/0", BUS_DATA_OE, BUS_DATA_OUT, IRQ_RAISE);
        end
        Reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus_rd(8'hF0 + 8'(i), d, oe);
            total++;
            if (d !== 8'h00 || oe !== 1'b1) begin
                bad++; $display("FAIL reset_reg%0d got=%h oe=%b want=00 oe=1", i, d, oe);
            end
        end
    endtask

    task automatic test_oneshot();
        logic [7:0] d; logic oe;
        logic [7:0] exp_cnt [4] = '{8'd1, 8'd2, 8'd3, 8'd0};
        bus_wr(8'hF1, 8'd3);
        bus_wr(8'hF0, 8'h03);
        for (int i = 0; i < 4; i++) begin
            tick();
            if (i == 3) begin
                total++;
                if (IRQ_RAISE !== 1'b0) begin
                    bad++; $display("FAIL oneshot_irq_early got=%b want=0", IRQ_RAISE);
                end
                @(negedge CLK);
                total++;
                if (IRQ_RAISE !== 1'b1) begin
                    bad++; $display("FAIL oneshot_irq_rise got=%b want=1", IRQ_RAISE);
                end
            end
            bus_rd(8'hF2, d, oe);
            total++;
            if (d !== exp_cnt[i]) begin
                bad++; $display("FAIL oneshot_count%0d got=%h want=%h", i, d, exp_cnt[i]);
            end
        end
        bus_rd(8'hF3, d, oe);
        total++;
        if (d !== 8'h03) begin
            bad++; $display("FAIL oneshot_status got=%h want=03", d);
        end
        tick(); tick();
        bus_rd(8'hF2, d, oe);
        total++;
        if (d !== 8'h00) begin
            bad++; $display("FAIL oneshot_done_hold got=%h want=00", d);
        end
        bus_wr(8'hF3, 8'h03);
        bus_rd(8'hF3, d, oe);
        total++;
        if (d !== 8'h00 || IRQ_RAISE !== 1'b0) begin
            bad++; $display("FAIL oneshot_clear status=%h irq=%b want=00/0", d, IRQ_RAISE);
        end
    endtask

    task automatic test_autoreload();
        logic [7:0] d; logic oe;
        bus_wr(8'hF1, 8'd1);
        bus_wr(8'hF0, 8'h07);
        for (int k = 0; k < 3; k++) begin
            tick();
            tick();
            @(negedge CLK);
            total++;
            if (IRQ_RAISE !== 1'b1) begin
                bad++; $display("FAIL auto_irq_rise%0d got=%b want=1", k, IRQ_RAISE);
            end
            @(negedge CLK);
            IRQ_ACK = 1'b1;
            @(negedge CLK);
            IRQ_ACK = 1'b0;
            total++;
            if (IRQ_RAISE !== 1'b1) begin
                bad++; $display("FAIL auto_irq_hold%0d got=%b want=1", k, IRQ_RAISE);
            end
            @(negedge CLK);
            total++;
            if (IRQ_RAISE !== 1'b0) begin
                bad++; $display("FAIL auto_irq_fall%0d got=%b want=0", k, IRQ_RAISE);
            end
        end
        bus_rd(8'hF3, d, oe);
        total++;
        if (d !== 8'h00) begin
            bad++; $display("FAIL auto_status got=%h want=00", d);
        end
    endtask

    task automatic test_ack_collision();
        logic [7:0] d; logic oe;
        bus_wr(8'hF1, 8'd0);
        @(negedge CLK);
        TICK_IN = 1'b1; IRQ_ACK = 1'b1;
        @(negedge CLK);
        TICK_IN = 1'b0; IRQ_ACK = 1'b0;
        @(negedge CLK);
        total++;
        if (IRQ_RAISE !== 1'b1) begin
            bad++; $display("FAIL collide_irq got=%b want=1", IRQ_RAISE);
        end
        bus_rd(8'hF3, d, oe);
        total++;
        if (d !== 8'h01) begin
            bad++; $display("FAIL collide_status got=%h want=01", d);
        end
        @(negedge CLK);
        IRQ_ACK = 1'b1;
        @(negedge CLK);
        IRQ_ACK = 1'b0;
    endtask

    task automatic test_period_shrink();
        logic [7:0] d; logic oe;
        bus_wr(8'hF0, 8'h01);
        bus_wr(8'hF1, 8'd8);
        repeat (5) tick();
        bus_rd(8'hF2, d, oe);
        total++;
        if (d !== 8'd5) begin
            bad++; $display("FAIL shrink_count5 got=%h want=05", d);
        end
        bus_wr(8'hF1, 8'd2);
        bus_rd(8'hF1, d, oe);
        total++;
        if (d !== 8'd2) begin
            bad++; $display("FAIL shrink_period got=%h want=02", d);
        end
        tick();
        bus_rd(8'hF2, d, oe);
        total++;
        if (d !== 8'd0) begin
            bad++; $display("FAIL shrink_expire got=%h want=00", d);
        end
        bus_rd(8'hF3, d, oe);
        total++;
        if (d !== 8'h03 || IRQ_RAISE !== 1'b0) begin
            bad++; $display("FAIL shrink_status status=%h irq=%b want=03/0", d, IRQ_RAISE);
        end
        bus_wr(8'hF0, 8'h00);
        bus_rd(8'hF3, d, oe);
        total++;
        if (d !== 8'h03) begin
            bad++; $display("FAIL status_keep_on_disable got=%h want=03", d);
        end
        bus_wr(8'hF3, 8'h03);
    endtask

    task automatic test_reset_midcount();
        logic [7:0] d; logic oe;
        bus_wr(8'hF1, 8'd0);
        bus_wr(8'hF0, 8'h07);
        tick();
        bus_wr(8'hF1, 8'd8);
        repeat (4) tick();
        bus_rd(8'hF2, d, oe);
        total++;
        if (d !== 8'd4 || IRQ_RAISE !== 1'b1) begin
            bad++; $display("FAIL midrst_pre count=%h irq=%b want=04/1", d, IRQ_RAISE);
        end
        @(negedge CLK);
        Reset = 1'b1; BUS_ADDR = 8'hF2; TICK_IN = 1'b1; IRQ_ACK = 1'b1;
        @(negedge CLK);
        Reset = 1'b0; TICK_IN = 1'b0; IRQ_ACK = 1'b0;
        total++;
        if (IRQ_RAISE !== 1'b0 || BUS_DATA_OE !== 1'b0 || BUS_DATA_OUT !== 8'h00) begin
            bad++; $display("FAIL midrst_outputs irq=%b oe=%b out=%h want 0/0/00", IRQ_RAISE, BUS_DATA_OE, BUS_DATA_OUT);
        end
        @(negedge CLK);
        BUS_ADDR = 8'h00;
        total++;
        if (BUS_DATA_OE !== 1'b1 || BUS_DATA_OUT !== 8'h00) begin
            bad++; $display("FAIL midrst_count_read oe=%b out=%h want 1/00", BUS_DATA_OE, BUS_DATA_OUT);
        end
        bus_rd(8'hF3, d, oe);
        total++;
        if (d !== 8'h00) begin
            bad++; $display("FAIL midrst_status got=%h want=00", d);
        end
    endtask

    task automatic test_ctrl_priority();
        logic [7:0] d; logic oe;
        bus_wr(8'hF1, 8'd5);
        bus_wr(8'hF0, 8'h01);
        tick(); tick();
        @(negedge CLK);
        BUS_ADDR = 8'hF0; BUS_DATA_IN = 8'h01; BUS_WE = 1'b1; TICK_IN = 1'b1;
        @(negedge CLK);
        BUS_WE = 1'b0; TICK_IN = 1'b0; BUS_ADDR = 8'h00;
        bus_rd(8'hF2, d, oe);
        total++;
        if (d !== 8'd0) begin
            bad++; $display("FAIL ctrl_prio_count got=%h want=00", d);
        end
        tick();
        bus_rd(8'hF2, d, oe);
        total++;
        if (d !== 8'd1) begin
            bad++; $display("FAIL ctrl_prio_run got=%h want=01", d);
        end
        bus_rd(8'hF4, d, oe);
        total++;
        if (oe !== 1'b0 || d !== 8'h00) begin
            bad++; $display("FAIL read_above oe=%b d=%h want 0/00", oe, d);
        end
        bus_rd(8'hEF, d, oe);
        total++;
        if (oe !== 1'b0 || d !== 8'h00) begin
            bad++; $display("FAIL read_below oe=%b d=%h want 0/00", oe, d);
        end
        bus_wr(8'hF2, 8'h07);
        bus_wr(8'hF4, 8'h00);
        bus_rd(8'hF2, d, oe);
        total++;
        if (d !== 8'd1) begin
            bad++; $display("FAIL ignored_writes count=%h want=01", d);
        end
        bus_wr(8'hF0, 8'hFF);
        bus_rd(8'hF0, d, oe);
        total++;
        if (d !== 8'h07) begin
            bad++; $display("FAIL ctrl_unused_bits got=%h want=07", d);
        end
        bus_wr(8'hF0, 8'h00);
        tick();
        bus_rd(8'hF2, d, oe);
        total++;
        if (d !== 8'd0) begin
            bad++; $display("FAIL idle_ignores_tick got=%h want=00", d);
        end
    endtask

    initial begin
        Reset = 1'b1; TICK_IN = 1'b0; BUS_ADDR = 8'h00; BUS_DATA_IN = 8'h00;
        BUS_WE = 1'b0; IRQ_ACK = 1'b0;
        test_reset();
        test_oneshot();
        test_autoreload();
        test_ack_collision();
        test_period_shrink();
        test_reset_midcount();
        test_ctrl_priority();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
